// File: rtl/squeeze_stream_ctrl.sv
// Squeeze-phase controller: pulls rate blocks from the permutation core into a PISO
// buffer and streams exactly out_len words to a ready/valid sink.
module squeeze_stream_ctrl #(
    parameter int DEPTH = 17,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] out_len,
    input  logic             block_valid,
    output logic             block_ready,
    output logic             perm_req,
    output logic             buf_write_enable,
    output logic             buf_shift_enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        STREAM,
        DONE
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] remaining_q;
    logic [CNT_W-1:0] word_cnt_q;

    logic in_wait;
    logic in_stream;
    logic xfer;
    logic last_word;
    logic blk_end;

    // Strobes are qualified with rst so they read 0 in the reset cycle itself,
    // before the synchronous reset has had an edge to clear the state.
    assign in_wait   = rst && (state_q == WAIT_BLOCK);
    assign in_stream = rst && (state_q == STREAM);
    assign xfer      = in_stream && out_ready;
    assign last_word = (remaining_q == LEN_W'(1));
    assign blk_end   = (word_cnt_q == CNT_W'(DEPTH - 1));

    assign block_ready      = in_wait && block_valid;
    assign buf_write_enable = in_wait && block_valid;
    assign buf_shift_enable = xfer;
    assign out_valid        = in_stream;
    assign out_last         = in_stream && last_word;
    assign perm_req         = xfer && !last_word && blk_end;
    assign busy             = rst && (state_q != IDLE);
    assign done             = rst && (state_q == DONE);

    // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (out_len != '0) begin
                            remaining_q <= out_len;
                            word_cnt_q  <= '0;
                            state_q     <= WAIT_BLOCK;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                WAIT_BLOCK: begin
                    if (block_valid) begin
                        word_cnt_q <= '0;
                        state_q    <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        word_cnt_q  <= word_cnt_q + CNT_W'(1);
                        // Final word wins over the block boundary: no wasted permutation.
                        if (last_word) begin
                            state_q <= DONE;
                        end else if (blk_end) begin
                            state_q <= WAIT_BLOCK;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_squeeze_stream_ctrl.sv
// Directed bench for squeeze_stream_ctrl with DEPTH=4: job vectors with hand-computed
// block, permutation and word counts, plus reset and abort behaviour.
module tb_squeeze_stream_ctrl;

    localparam int DEPTH = 4;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] out_len;
    logic             block_valid;
    logic             block_ready;
    logic             perm_req;
    logic             buf_write_enable;
    logic             buf_shift_enable;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_bad    = 0;

    squeeze_stream_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .out_len          (out_len),
        .block_valid      (block_valid),
        .block_ready      (block_ready),
        .perm_req         (perm_req),
        .buf_write_enable (buf_write_enable),
        .buf_shift_enable (buf_shift_enable),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_vec();
        return int'({block_ready, perm_req, buf_write_enable, buf_shift_enable,
                     out_valid, out_last, busy, done});
    endfunction

    // One job from start to a little past done. Inputs change 1 time unit after the
    // rising edge; outputs are sampled on the falling edge.
    task automatic run_job(input string name, input int len, input bit rnd_ready,
                           input bit extra_start, input int exp_writes,
                           input int exp_perms, input int exp_perm_sum);
        int writes = 0, xfers = 0, perms = 0, perm_sum = 0, dones = 0;
        int last_cnt = 0, last_idx = 0, last_xfer_cyc = -1, done_cyc = -100;
        int gaps = 0, shift_viol = 0, both_viol = 0, stall_viol = 0, perm_viol = 0;
        int idle_viol = 0, busy_post = 1, valid_cnt = 0;
        bit seen_valid = 0, prev_valid = 0, prev_ready = 0, prev_last = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            start       = (cyc == 0) || (extra_start && cyc == 3);
            out_len     = (cyc == 0) ? LEN_W'(len) : LEN_W'(7);
            block_valid = 1'b1;
            out_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (cyc == 0 && (block_ready || buf_write_enable || busy)) idle_viol++;
            if (buf_shift_enable != (out_valid && out_ready)) shift_viol++;
            if (buf_write_enable && buf_shift_enable) both_viol++;
            if (perm_req && !(out_valid && out_ready)) perm_viol++;
            if (prev_valid && !prev_ready && (!out_valid || out_last != prev_last)) stall_viol++;
            if (seen_valid && xfers < len && !out_valid) gaps++;
            if (out_valid) begin
                seen_valid = 1;
                valid_cnt++;
            end
            if (buf_write_enable) writes++;
            if (out_valid && out_ready) begin
                xfers++;
                last_xfer_cyc = cyc;
                if (out_last) begin
                    last_cnt++;
                    last_idx = xfers;
                end
                if (perm_req) begin
                    perms++;
                    perm_sum += xfers;
                end
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (cyc == done_cyc + 1) busy_post = int'(busy);
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_last  = out_last;
            @(posedge clk);
            #1;
            if (cyc >= done_cyc + 2 && dones > 0) break;
        end
        start = 1'b0;
        check({name, ".transfers"}, xfers, len);
        check({name, ".writes"}, writes, exp_writes);
        check({name, ".perm_req"}, perms, exp_perms);
        check({name, ".perm_pos"}, perm_sum, exp_perm_sum);
        check({name, ".done_cnt"}, dones, 1);
        check({name, ".shift_rule"}, shift_viol + both_viol + perm_viol, 0);
        check({name, ".stall_hold"}, stall_viol, 0);
        check({name, ".idle_ignore"}, idle_viol, 0);
        check({name, ".valid_gaps"}, gaps, exp_perms);
        check({name, ".busy_after"}, busy_post, 0);
        if (len > 0) begin
            check({name, ".last_cnt"}, last_cnt, 1);
            check({name, ".last_idx"}, last_idx, len);
            check({name, ".done_lat"}, done_cyc - last_xfer_cyc, 1);
        end else begin
            check({name, ".no_valid"}, valid_cnt, 0);
            check({name, ".done_cyc"}, done_cyc, 1);
        end
    endtask

    initial begin
        int xfers;
        int dones;
        rst         = 1'b0;
        start       = 1'b1;
        out_len     = LEN_W'(5);
        block_valid = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        check("rst_during_first", outs_vec(), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_during", outs_vec(), 0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst_after", outs_vec(), 0);
        @(posedge clk);
        #1;

        //      name       len rnd extra writes perms perm_sum
        run_job("len3",      3, 0, 0,    1,     0,    0);
        run_job("len10",    10, 0, 1,    3,     2,   12);
        run_job("len4",      4, 0, 0,    1,     0,    0);
        run_job("len4_rnd",  4, 1, 0,    1,     0,    0);
        run_job("len9_rnd",  9, 1, 0,    3,     2,   12);
        run_job("len0",      0, 0, 0,    0,     0,    0);
        run_job("len1",      1, 0, 0,    1,     0,    0);

        // Abort a len=6 job with a one-cycle reset right after its second transfer.
        xfers = 0;
        dones = 0;
        for (int cyc = 0; cyc < 20 && xfers < 2; cyc++) begin
            start       = (cyc == 0);
            out_len     = LEN_W'(6);
            block_valid = 1'b1;
            out_ready   = 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) xfers++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("abort.xfers_before", xfers, 2);
        rst = 1'b0;
        @(negedge clk);
        check("abort.outs_in_rst", outs_vec(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort.outs_after", outs_vec(), 0);
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (done || busy || out_valid || buf_write_enable) dones++;
        end
        @(posedge clk);
        #1;
        check("abort.quiet", dones, 0);
        run_job("post_abort", 5, 0, 0, 2, 1, 4);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
